// File: rtl/tie_release_seq.sv
`default_nettype none
// ============================================================================
// Module   : tie_release_seq
// Purpose  : Staged enable sequencer. Holds STAGES downstream enables at the
//            tie-off (low) level after reset. On a start pulse it releases them
//            one at a time, lowest bit first. Each release follows a
//            programmable delay, and the next stage waits for the released
//            stage to acknowledge. Abort returns every enable low. With the
//            optional ack timeout, a missing acknowledge also returns every
//            enable low.
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            start        - 1-cycle pulse, accepted only in IDLE
//            abort        - level, forces IDLE with all enables low
//            stage_delay  - delay per stage, sampled on an accepted start
//            stage_ack    - per-stage ready, bit i gates release of stage i+1
//            en_out       - sequenced enables (registered)
//            busy         - delaying or waiting for an ack (registered)
//            done         - all stages released and acked (registered)
//            fault        - ack timeout occurred (registered)
// Config   : SEQ_ACK_TIMEOUT_EN - when defined, a stage that is not acked
//            within ACK_TO+1 cycles drives the sequencer into FAULT. When it
//            is undefined, WAIT_ACK waits forever and fault is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module tie_release_seq #(
  parameter int STAGES  = 4,
  parameter int DELAY_W = 8,
  parameter int ACK_TO  = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] stage_delay,
  input  logic [STAGES-1:0]  stage_ack,
  output logic [STAGES-1:0]  en_out,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_DLY = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_DONE     = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [STAGES-1:0]  en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SEQ_ACK_TIMEOUT_EN
  localparam int ATO_W = (ACK_TO < 1) ? 1 : $clog2(ACK_TO + 1);
  logic [ATO_W-1:0]   ato_q, ato_d;
  logic               fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    en_d    = en_q;
`ifdef SEQ_ACK_TIMEOUT_EN
    ato_d   = ato_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // A zero delay behaves as one, so the counter never starts at zero.
          dly_d   = (stage_delay == '0) ? DELAY_W'(1) : stage_delay;
          cnt_d   = (stage_delay == '0) ? DELAY_W'(1) : stage_delay;
          idx_d   = '0;
          state_d = S_WAIT_DLY;
        end
      end

      S_WAIT_DLY: begin
        // The count starts at one or more, and this state is left when it
        // reaches one, so it never underflows.
        if (cnt_q == DELAY_W'(1)) begin
          en_d[idx_q] = 1'b1;
`ifdef SEQ_ACK_TIMEOUT_EN
          ato_d       = ATO_W'(ACK_TO);
`endif
          state_d     = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end

      S_WAIT_ACK: begin
        // Only the ack of the stage just released counts. An ack that
        // arrives in the same cycle the timer expires still wins.
        if (stage_ack[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = dly_q;
            state_d = S_WAIT_DLY;
          end
        end
`ifdef SEQ_ACK_TIMEOUT_EN
        else if (ato_q == '0) begin
          en_d    = '0;
          state_d = S_FAULT;
        end else begin
          ato_d = ato_q - ATO_W'(1);
        end
`endif
      end

      S_DONE:  ;
      S_FAULT: ;
      default: begin
        en_d    = '0;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides start, ack and timeout in the same cycle.
    if (abort) begin
      state_d = S_IDLE;
      en_d    = '0;
      idx_d   = '0;
      cnt_d   = '0;
`ifdef SEQ_ACK_TIMEOUT_EN
      ato_d   = '0;
`endif
    end
  end

  // The status flags are decoded from the next state, so they are registered
  // in the same cycle as the state they describe.
  always_comb begin
    busy_d  = (state_d == S_WAIT_DLY) || (state_d == S_WAIT_ACK);
    done_d  = (state_d == S_DONE);
`ifdef SEQ_ACK_TIMEOUT_EN
    fault_d = (state_d == S_FAULT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
      ato_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_ACK_TIMEOUT_EN
      ato_q   <= ato_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign en_out = en_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef SEQ_ACK_TIMEOUT_EN
  assign fault  = fault_q;
`else
  assign fault  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tie_release_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tie_release_seq
// Purpose  : Self-checking bench for tie_release_seq. A transaction-level
//            model tracks the number of released stages, the cycles left
//            before the next release and the cycles spent waiting for an
//            ack. It compares the DUT against that model every cycle. Directed
//            scenarios add literal timing and value checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tie_release_seq;

  localparam int STAGES    = 4;
  localparam int DELAY_W   = 8;
  localparam int TB_ACK_TO = 10;

  localparam int M_IDLE  = 0;
  localparam int M_DELAY = 1;
  localparam int M_ACK   = 2;
  localparam int M_DONE  = 3;
  localparam int M_FAULT = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [DELAY_W-1:0] stage_delay;
  logic [STAGES-1:0]  stage_ack;
  logic [STAGES-1:0]  en_out;
  logic               busy;
  logic               done;
  logic               fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: operating mode, number of stages currently released,
  // stage being worked on, cycles left until the next release, latched
  // delay and cycles spent waiting for an ack.
  int m_mode, m_rel, m_stage, m_left, m_dly, m_waited;

  tie_release_seq #(
    .STAGES (STAGES),
    .DELAY_W(DELAY_W),
    .ACK_TO (TB_ACK_TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .stage_delay(stage_delay),
    .stage_ack  (stage_ack),
    .en_out     (en_out),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
    $fatal(1);
  end

  task automatic model_reset();
    m_mode = M_IDLE; m_rel = 0; m_stage = 0; m_left = 0; m_dly = 0; m_waited = 0;
  endtask

  task automatic model_step();
    if (abort) begin
      m_mode = M_IDLE; m_rel = 0; m_stage = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (start) begin
        m_dly   = (stage_delay == 0) ? 1 : int'(stage_delay);
        m_left  = m_dly;
        m_stage = 0;
        m_mode  = M_DELAY;
      end
      M_DELAY: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_rel    = m_stage + 1;
          m_waited = 0;
          m_mode   = M_ACK;
        end
      end
      M_ACK: begin
        if (stage_ack[m_stage]) begin
          if (m_stage == STAGES - 1) m_mode = M_DONE;
          else begin
            m_stage = m_stage + 1;
            m_left  = m_dly;
            m_mode  = M_DELAY;
          end
        end else begin
`ifdef SEQ_ACK_TIMEOUT_EN
          m_waited = m_waited + 1;
          if (m_waited > TB_ACK_TO) begin
            m_mode = M_FAULT;
            m_rel  = 0;
          end
`endif
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, sampled after the falling edge.
  initial begin
    logic [STAGES-1:0] exp_en;
    int                mask;
    forever begin
      @(negedge clk);
      #1;
      mask   = (1 << m_rel) - 1;
      exp_en = mask[STAGES-1:0];
      n_cmp++;
      if (en_out !== exp_en ||
          busy  !== (m_mode == M_DELAY || m_mode == M_ACK) ||
          done  !== (m_mode == M_DONE) ||
          fault !== (m_mode == M_FAULT)) begin
        n_bad++;
        $display("FAIL model t=%0t: got en=%h busy=%b done=%b fault=%b, expected en=%h busy=%b done=%b fault=%b",
                 $time, en_out, busy, done, fault, exp_en,
                 (m_mode == M_DELAY || m_mode == M_ACK), (m_mode == M_DONE), (m_mode == M_FAULT));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and directed samples are taken 2 time units after the
  // falling edge, well away from the rising edge.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_en(input int i, output int n);
    n = 0;
    while (en_out[i] !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_en%0d: got timeout expected enable rise", i);
    end
  endtask

  initial begin
    int n;
    logic [STAGES-1:0] seq_tbl [STAGES];
    seq_tbl[0] = 4'h1; seq_tbl[1] = 4'h3; seq_tbl[2] = 4'h7; seq_tbl[3] = 4'hF;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stage_delay = '0; stage_ack = '0;
    step(); step();
    check("reset_en", 32'(en_out), 32'h0);
    check("reset_flags", {29'd0, busy, done, fault}, 32'h0);
    rst_n = 1'b1;

    // Idle after reset release: nothing may move without a start.
    repeat (50) step();
    check("idle50_en", 32'(en_out), 32'h0);

    // Delay of 3, each ack 2 cycles after its enable.
    stage_delay = 8'd3;
    start = 1'b1; step(); start = 1'b0;
    wait_en(0, n);
    check("t2_lat0", n + 1, 4);
    check("t2_seq0", 32'(en_out), 32'(seq_tbl[0]));
    for (int i = 1; i < STAGES; i++) begin
      step(); step();
      stage_ack[i-1] = 1'b1;
      wait_en(i, n);
      check($sformatf("t2_lat%0d", i), n, 4);
      check($sformatf("t2_seq%0d", i), 32'(en_out), 32'(seq_tbl[i]));
    end
    step(); step();
    stage_ack[3] = 1'b1;
    step();
    check("t2_done", 32'(done), 32'h1);
    check("t2_busy", 32'(busy), 32'h0);
    start = 1'b1; step(); start = 1'b0; step();
    check("t2_done_hold", 32'(en_out), 32'hF);
    abort = 1'b1; step(); abort = 1'b0; stage_ack = '0;
    check("t2_abort", 32'(en_out), 32'h0);

    // Zero delay behaves as one; acks held high.
    stage_delay = 8'd0; stage_ack = '1;
    start = 1'b1; step(); start = 1'b0;
    wait_en(0, n);
    check("t3_lat0", n + 1, 2);
    for (int i = 1; i < STAGES; i++) begin
      wait_en(i, n);
      check($sformatf("t3_gap%0d", i), n, 2);
    end
    step();
    check("t3_done", 32'(done), 32'h1);
    abort = 1'b1; step(); abort = 1'b0; stage_ack = '0;

    // Abort in WAIT_ACK of stage 2 with a simultaneous start.
    stage_delay = 8'd1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_en(i, n);
      stage_ack[i] = 1'b1;
    end
    wait_en(2, n);
    check("t4_pre", 32'(en_out), 32'h7);
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    check("t4_en", 32'(en_out), 32'h0);
    step();
    check("t4_dropped", 32'(busy), 32'h0);
    stage_ack = '0;

    // Stage 1 never acked.
    stage_delay = 8'd2;
    start = 1'b1; step(); start = 1'b0;
    wait_en(0, n);
    stage_ack[0] = 1'b1;
    wait_en(1, n);
    repeat (8) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (12) step();
`ifdef SEQ_ACK_TIMEOUT_EN
    check("t5_fault", 32'(fault), 32'h1);
    check("t5_en", 32'(en_out), 32'h0);
`else
    check("t5_busy", 32'(busy), 32'h1);
    check("t5_fault", 32'(fault), 32'h0);
    check("t5_en", 32'(en_out), 32'h3);
`endif
    abort = 1'b1; step(); abort = 1'b0; stage_ack = '0;
    check("t5_clear", {29'd0, busy, done, fault}, 32'h0);

    // Asynchronous reset during the delay before stage 3, then a fresh run.
    stage_delay = 8'd4;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_en(i, n);
      step();
      stage_ack[i] = 1'b1;
    end
    step(); step();
    check("t6_pre", 32'(en_out), 32'h7);
    rst_n = 1'b0;
    #1;
    check("t6_async", 32'(en_out), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    step(); step();
    rst_n = 1'b1; stage_ack = '0;
    step();
    stage_delay = 8'd5;
    start = 1'b1; step(); start = 1'b0;
    wait_en(0, n);
    check("t6_lat0", n + 1, 6);
    for (int i = 1; i < STAGES; i++) begin
      step();
      stage_ack[i-1] = 1'b1;
      wait_en(i, n);
    end
    step();
    stage_ack[3] = 1'b1;
    step();
    check("t6_done", 32'(done), 32'h1);
    abort = 1'b1; step(); abort = 1'b0; stage_ack = '0;

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      start       = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 63) == 0);
      stage_ack   = STAGES'($urandom);
      stage_delay = ($urandom_range(0, 9) == 0) ? DELAY_W'($urandom_range(7, 20))
                                                : DELAY_W'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_async", 32'(en_out), 32'h0);
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    start = 1'b0; abort = 1'b0; stage_ack = '0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
